// File: rtl/ip_msx50bus_arbiter.sv
// ip_msx50bus_arbiter
//   Takes one latched I/O or memory request from the MSX50BUS bridge, decodes
//   it to I/O window 0, I/O window 1 or memory, runs the target handshake and
//   returns a single bus_ack. Unmapped I/O ports and hung targets are
//   auto-completed so the bridge never stalls.
//
// Ports
//   clk, n_reset                       clock, async active-low reset
//   bus_address/io_req/memory_req      request from bridge (levels held to ack)
//   bus_wrt/bus_wdata                  direction and write data
//   bus_ack/bus_rdata/bus_rdata_en     completion pulse and read data to bridge
//   tgt_req/address/wrt/wdata          one-hot request and latched cycle info
//   tgt_ack/tgt_rdata/tgt_rdata_en     per-target responses (target n on [n])
//   timeout_flag                       pulse on forced completion
module ip_msx50bus_arbiter #(
   parameter logic [7:0]  IO0_BASE = 8'h10,
   parameter logic [7:0]  IO0_MASK = 8'hFE,
   parameter logic [7:0]  IO1_BASE = 8'h7C,
   parameter logic [7:0]  IO1_MASK = 8'hFE,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] bus_address,
   input  logic        bus_io_req,
   input  logic        bus_memory_req,
   input  logic        bus_wrt,
   input  logic [7:0]  bus_wdata,
   output logic        bus_ack,
   output logic [7:0]  bus_rdata,
   output logic        bus_rdata_en,
   output logic [2:0]  tgt_req,
   output logic [15:0] tgt_address,
   output logic        tgt_wrt,
   output logic [7:0]  tgt_wdata,
   input  logic [2:0]  tgt_ack,
   input  logic [23:0] tgt_rdata,
   input  logic [2:0]  tgt_rdata_en,
   output logic        timeout_flag
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [2:0]  tgt_req_q, tgt_req_d;
   logic [15:0] addr_q, addr_d;
   logic        wrt_q, wrt_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        cap_q, cap_d;
   logic        bus_ack_q, bus_ack_d;
   logic [7:0]  bus_rdata_q, bus_rdata_d;
   logic        bus_rdata_en_q, bus_rdata_en_d;
   logic        tmo_flag_q, tmo_flag_d;

   logic [2:0]  sel_new;
   logic        ack_hit, rd_hit;
   logic [7:0]  rd_byte;

   // Decode of the incoming request; I/O wins when both request levels are up.
   // An all-zero select means an unmapped I/O port.
   always_comb begin
      sel_new = 3'b000;
      if (bus_io_req) begin
         if ((bus_address[7:0] & IO0_MASK) == (IO0_BASE & IO0_MASK))
            sel_new = 3'b001;
         else if ((bus_address[7:0] & IO1_MASK) == (IO1_BASE & IO1_MASK))
            sel_new = 3'b010;
      end else begin
         sel_new = 3'b100;
      end
   end

   // tgt_req_q is one-hot while in ACCESS, so it doubles as the target select
   // and masks out responses from the other targets.
   always_comb begin
      rd_byte = 8'h00;
      if (tgt_req_q[0]) rd_byte = tgt_rdata[7:0];
      if (tgt_req_q[1]) rd_byte = tgt_rdata[15:8];
      if (tgt_req_q[2]) rd_byte = tgt_rdata[23:16];
   end

   assign ack_hit = |(tgt_ack & tgt_req_q);
   assign rd_hit  = ~wrt_q & (|(tgt_rdata_en & tgt_req_q));

   always_comb begin
      state_d        = state_q;
      tgt_req_d      = tgt_req_q;
      addr_d         = addr_q;
      wrt_d          = wrt_q;
      wdata_d        = wdata_q;
      cnt_d          = cnt_q;
      cap_d          = cap_q;
      bus_rdata_d    = bus_rdata_q;
      bus_ack_d      = 1'b0;
      bus_rdata_en_d = 1'b0;
      tmo_flag_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus_io_req | bus_memory_req) begin
               addr_d  = bus_address;
               wrt_d   = bus_wrt;
               wdata_d = bus_wdata;
               cnt_d   = 8'h00;
               cap_d   = 1'b0;
               if (sel_new != 3'b000) begin
                  tgt_req_d = sel_new;
                  state_d   = S_ACCESS;
               end else begin
                  // Unmapped port: complete next cycle with no read data.
                  state_d   = S_DONE;
                  bus_ack_d = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            if (rd_hit) begin
               bus_rdata_d = rd_byte;
               cap_d       = 1'b1;
            end
            // An ack on the expiry cycle still counts as a normal completion.
            if (ack_hit) begin
               tgt_req_d      = 3'b000;
               state_d        = S_DONE;
               bus_ack_d      = 1'b1;
               bus_rdata_en_d = cap_q | rd_hit;
            end else if (cnt_q == TMO_LAST) begin
               tgt_req_d  = 3'b000;
               state_d    = S_DONE;
               bus_ack_d  = 1'b1;
               tmo_flag_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'h01;
            end
         end
         S_DONE: begin
            // Pulses were registered on entry; the bridge drops its request now.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q        <= S_IDLE;
         tgt_req_q      <= 3'b000;
         addr_q         <= 16'h0000;
         wrt_q          <= 1'b0;
         wdata_q        <= 8'h00;
         cnt_q          <= 8'h00;
         cap_q          <= 1'b0;
         bus_ack_q      <= 1'b0;
         bus_rdata_q    <= 8'h00;
         bus_rdata_en_q <= 1'b0;
         tmo_flag_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         tgt_req_q      <= tgt_req_d;
         addr_q         <= addr_d;
         wrt_q          <= wrt_d;
         wdata_q        <= wdata_d;
         cnt_q          <= cnt_d;
         cap_q          <= cap_d;
         bus_ack_q      <= bus_ack_d;
         bus_rdata_q    <= bus_rdata_d;
         bus_rdata_en_q <= bus_rdata_en_d;
         tmo_flag_q     <= tmo_flag_d;
      end
   end

   assign bus_ack      = bus_ack_q;
   assign bus_rdata    = bus_rdata_q;
   assign bus_rdata_en = bus_rdata_en_q;
   assign tgt_req      = tgt_req_q;
   assign tgt_address  = addr_q;
   assign tgt_wrt      = wrt_q;
   assign tgt_wdata    = wdata_q;
   assign timeout_flag = tmo_flag_q;

endmodule

// File: tb/tb_ip_msx50bus_arbiter.sv
// Testbench for ip_msx50bus_arbiter: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_ip_msx50bus_arbiter;

   // Timeout of 6 lets a 5-cycle memory access complete normally while the
   // never-acking case still expires.
   localparam int TMO = 6;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [15:0] bus_address;
   logic        bus_io_req, bus_memory_req, bus_wrt;
   logic [7:0]  bus_wdata;
   logic        bus_ack, bus_rdata_en, tgt_wrt, timeout_flag;
   logic [7:0]  bus_rdata, tgt_wdata;
   logic [2:0]  tgt_req, tgt_ack, tgt_rdata_en;
   logic [15:0] tgt_address;
   logic [23:0] tgt_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ip_msx50bus_arbiter #(.TIMEOUT(TMO)) u_dut (
      .clk(clk), .n_reset(n_reset),
      .bus_address(bus_address), .bus_io_req(bus_io_req),
      .bus_memory_req(bus_memory_req), .bus_wrt(bus_wrt), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en),
      .tgt_req(tgt_req), .tgt_address(tgt_address), .tgt_wrt(tgt_wrt),
      .tgt_wdata(tgt_wdata), .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata),
      .tgt_rdata_en(tgt_rdata_en), .timeout_flag(timeout_flag)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Address map: ports 0x10/0x11 -> window 0, 0x7C/0x7D -> window 1.
   function automatic int decode(input bit io, input logic [15:0] a);
      if (!io) return 2;
      if (a[7:0] inside {8'h10, 8'h11}) return 0;
      if (a[7:0] inside {8'h7C, 8'h7D}) return 1;
      return 3;
   endfunction

   task automatic idle_inputs();
      bus_io_req     = 1'b0;
      bus_memory_req = 1'b0;
      tgt_ack        = 3'b000;
      tgt_rdata_en   = 3'b000;
      tgt_rdata      = 24'h0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"},   32'(tgt_req), 32'h0);
      chk({tag, "_ack"},   32'(bus_ack), 32'h0);
      chk({tag, "_ren"},   32'(bus_rdata_en), 32'h0);
      chk({tag, "_tmo"},   32'(timeout_flag), 32'h0);
      chk({tag, "_rdata"}, 32'(bus_rdata), 32'h0);
      chk({tag, "_addr"},  32'({tgt_address, tgt_wdata, 7'b0, tgt_wrt}), 32'h0);
   endtask

   // One bridge transaction. ack_at = index of the ACCESS cycle where the
   // selected target acks (>= TMO means never). pen/rdv give the selected
   // target's read-data pulses per ACCESS cycle. Starts and ends at posedge+1.
   task automatic txn(input bit io, input bit mem, input logic [15:0] a,
                      input bit wr, input logic [7:0] wd, input int ack_at,
                      input logic [TMO-1:0] pen, input logic [TMO-1:0][7:0] rdv);
      int         tgt, n, k;
      bit         hit, tmo, cap, exp_ren;
      logic [7:0] last;
      logic [2:0] oh, exp_req;
      tgt  = decode(io, a);
      hit  = (tgt != 3);
      n    = !hit ? 0 : (ack_at < TMO ? ack_at + 1 : TMO);
      tmo  = hit && (ack_at >= TMO);
      cap  = 1'b0;
      last = 8'h00;
      for (int i = 0; i < n; i++)
         if (pen[i]) begin cap = 1'b1; last = rdv[i]; end
      exp_ren = hit && !wr && !tmo && cap;
      oh      = hit ? 3'(1 << tgt) : 3'b000;

      bus_io_req = io; bus_memory_req = mem; bus_address = a;
      bus_wrt = wr; bus_wdata = wd;
      for (int c = 1; c <= n + 2; c++) begin
         @(posedge clk); #1;
         exp_req = (c <= n) ? oh : 3'b000;
         chk("tgt_req",      32'(tgt_req), 32'(exp_req));
         chk("bus_ack",      32'(bus_ack), 32'(c == n + 1));
         chk("bus_rdata_en", 32'(bus_rdata_en), 32'((c == n + 1) && exp_ren));
         chk("timeout_flag", 32'(timeout_flag), 32'((c == n + 1) && tmo));
         if (c == n + 1 && exp_ren) chk("bus_rdata", 32'(bus_rdata), 32'(last));
         if (c <= n) begin
            chk("tgt_address", 32'(tgt_address), 32'(a));
            chk("tgt_wrt",     32'(tgt_wrt), 32'(wr));
            chk("tgt_wdata",   32'(tgt_wdata), 32'(wd));
         end
         tgt_ack = 3'b000; tgt_rdata_en = 3'b000; tgt_rdata = 24'($urandom);
         if (c <= n) begin
            k = c - 1;
            // Non-selected targets chatter randomly; they must be ignored.
            tgt_ack      = 3'($urandom) & ~oh;
            tgt_rdata_en = 3'($urandom) & ~oh;
            if (k == ack_at) tgt_ack = tgt_ack | oh;
            if (pen[k])      tgt_rdata_en = tgt_rdata_en | oh;
            tgt_rdata[8*tgt +: 8] = rdv[k];
         end
         if (c >= n + 1) begin bus_io_req = 1'b0; bus_memory_req = 1'b0; end
      end
      idle_inputs();
   endtask

   logic [7:0]  ports [8] = '{8'h10, 8'h11, 8'h7C, 8'h7D, 8'h20, 8'h12, 8'h7E, 8'hFF};
   logic [15:0] ra;
   bit          rio, rmem;

   initial begin
      n_reset = 1'b0; bus_address = '0; bus_wrt = 1'b0; bus_wdata = '0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      n_reset = 1'b1;
      @(posedge clk); #1;

      // I/O read window 0 with immediate ack and data.
      txn(1, 0, 16'h0011, 0, 8'h00, 0, 6'b000001, 48'h0000_0000_00A5);
      // Memory write, target acks on its 5th request cycle.
      txn(0, 1, 16'h4000, 1, 8'h3C, 4, 6'b000000, 48'h0);
      // Unmapped port.
      txn(1, 0, 16'h0020, 0, 8'h00, 0, 6'b000001, 48'h11);
      // Window 1 never acks, then acks exactly on the expiry cycle.
      txn(1, 0, 16'h007D, 0, 8'h00, TMO, 6'b000010, 48'h5500);
      txn(1, 0, 16'h007D, 0, 8'h00, TMO - 1, 6'b000010, 48'h5500);
      // Write to a target that pulses rdata_en: no read data returned.
      txn(1, 0, 16'h007C, 1, 8'h99, 1, 6'b000011, 48'h7766);
      // I/O and memory together: I/O first, then memory as its own cycle.
      txn(1, 1, 16'h0010, 0, 8'h00, 1, 6'b000001, 48'h00C3);
      txn(0, 1, 16'h8123, 0, 8'h00, 2, 6'b000110, 48'hBB_AA00);

      // Reset while memory target is being accessed.
      bus_memory_req = 1'b1; bus_io_req = 1'b0; bus_address = 16'h2000; bus_wrt = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_req", 32'(tgt_req), 32'h4);
      #2 n_reset = 1'b0;
      #1 check_all_zero("rst_async");
      idle_inputs();
      @(posedge clk); #1;
      n_reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("rst_after_ack", 32'(bus_ack), 32'h0);
         chk("rst_after_req", 32'(tgt_req), 32'h0);
      end

      // Randomized traffic.
      for (int t = 0; t < 200; t++) begin
         rio  = 1'($urandom);
         rmem = rio ? 1'($urandom) : 1'b1;
         ra   = 16'($urandom);
         if ($urandom_range(0, 3) != 0) ra[7:0] = ports[$urandom_range(0, 7)];
         txn(rio, rmem, ra, 1'($urandom), 8'($urandom), int'($urandom_range(0, TMO)),
             TMO'($urandom), {16'($urandom), 32'($urandom)});
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop in case something wedges the stimulus.
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
